btn_press_meter: RTL

Downstream consumer of the debounced button level `Ux` and the 1 ms clock enable `ce1ms` produced by the button-conditioning stage. It turns the clean level into one-clock event pulses for press, short release and long-hold. It also measures each press duration in milliseconds and keeps a 4-digit BCD press counter for the 7-segment display stage.

---
 rtl/btn_press_meter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/btn_press_meter.sv
// btn_press_meter: turns the debounced button level into press, long-hold and
// release event pulses. It measures each press in milliseconds and keeps a
// 4-digit BCD count of completed presses.
module btn_press_meter #(
    parameter int unsigned LONG_MS = 500,
    parameter int unsigned DUR_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce1ms,
    input  logic             Ux,
    output logic             press_st,
    output logic             long_p,
    output logic             short_p,
    output logic             rel_p,
    output logic [DUR_W-1:0] dur_ms,
    output logic [15:0]      cnt_bcd,
    output logic             cnt_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HELD  = 2'd2
    } state_t;

    localparam logic [DUR_W-1:0] TMR_ONE  = DUR_W'(1);
    localparam logic [DUR_W-1:0] TMR_MAX  = '1;
    localparam logic [DUR_W-1:0] LONG_V   = DUR_W'(LONG_MS);
    localparam logic [DUR_W-1:0] LONG_M1  = DUR_W'(LONG_MS - 1);

    state_t           state;
    state_t           state_nxt;
    logic             Ux_q;
    logic             rise;
    logic             fall;
    logic [DUR_W-1:0] tmr;
    logic [DUR_W-1:0] tmr_nxt;
    logic             press_d;
    logic             long_d;
    logic             short_d;
    logic             rel_d;
    logic [15:0]      cnt_inc;
    logic             cnt_wrap;

    // Edge detection against the registered copy of the button level
    always_comb begin
        rise = Ux & ~Ux_q;
        fall = ~Ux & Ux_q;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, timer update and event strobes; a release beats a
    // coincident millisecond tick, so the tick is neither counted nor
    // allowed to raise a long-hold event
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        press_d   = 1'b0;
        long_d    = 1'b0;
        short_d   = 1'b0;
        rel_d     = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESS;
                    tmr_nxt   = '0;
                    press_d   = 1'b1;
                end
            end
            PRESS: begin
                if (fall) begin
                    state_nxt = IDLE;
                    short_d   = 1'b1;
                    rel_d     = 1'b1;
                end else if (ce1ms) begin
                    if (tmr == LONG_M1) begin
                        state_nxt = HELD;
                        tmr_nxt   = LONG_V;
                        long_d    = 1'b1;
                    end else begin
                        tmr_nxt = tmr + TMR_ONE;
                    end
                end
            end
            HELD: begin
                if (fall) begin
                    state_nxt = IDLE;
                    rel_d     = 1'b1;
                end else if (ce1ms && (tmr != TMR_MAX)) begin
                    tmr_nxt = tmr + TMR_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // BCD increment with a ripple carry through the four digits
    always_comb begin
        logic       carry;
        logic [3:0] dig;
        cnt_inc = cnt_bcd;
        carry   = 1'b1;
        dig     = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            dig = cnt_bcd[i*4 +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    cnt_inc[i*4 +: 4] = 4'd0;
                end else begin
                    cnt_inc[i*4 +: 4] = dig + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        cnt_wrap = carry;
    end

    // Registered outputs, timer, level copy, captured duration and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Ux_q     <= 1'b0;
            tmr      <= '0;
            press_st <= 1'b0;
            long_p   <= 1'b0;
            short_p  <= 1'b0;
            rel_p    <= 1'b0;
            dur_ms   <= '0;
            cnt_bcd  <= '0;
            cnt_ovf  <= 1'b0;
        end else begin
            Ux_q     <= Ux;
            tmr      <= tmr_nxt;
            press_st <= press_d;
            long_p   <= long_d;
            short_p  <= short_d;
            rel_p    <= rel_d;
            cnt_ovf  <= 1'b0;
            if (rel_d) begin
                dur_ms  <= tmr;
                cnt_bcd <= cnt_inc;
                cnt_ovf <= cnt_wrap;
            end
        end
    end

endmodule
